// File: rtl/stream_checker.sv
// stream_checker: self-checking stimulus/response harness for an FPGA datapath.
//
// Streams NUM_TESTS input vectors into a DUT over a valid/yumi handshake. It keeps up to
// MAX_INFLIGHT vectors outstanding. Each DUT output vector is taken over valid/ready and
// compared word by word against an expected vector, within a signed tolerance. Results go
// to registered status outputs for LEDs or an ILA.
//
// ROM contents are elaborated from the packed parameters TEST_INPUT_ROM and TEST_OUTPUT_ROM.
// These are generated from in.mif and out.mif by the build flow. Entry i occupies
// bits [i*W +: W], and word k of an entry occupies bits [k*WORD_SIZE +: WORD_SIZE].
//
// Ports:
//   clk_i, reset_n_i      clock (rising edge) and asynchronous active-low reset
//   start_i               start a run from IDLE or DONE (clears the statistics)
//   loop_i                sampled on the DRAIN->DONE edge; 1 reruns immediately
//   valid_o/yumi_i/data_o stimulus side; data_o is registered
//   ready_o/valid_i/data_i response side
//   busy_o, done_o, pass_o, error_count_o, first_fail_o, fail_seen_o   registered status
module stream_checker #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned NUM_WORDS    = 1,
  parameter int unsigned OUTPUT_SIZE  = 10,
  parameter int unsigned NUM_TESTS    = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned TOLERANCE    = 0,
  parameter logic [NUM_TESTS*NUM_WORDS*WORD_SIZE-1:0]   TEST_INPUT_ROM  = '0,
  parameter logic [NUM_TESTS*OUTPUT_SIZE*WORD_SIZE-1:0] TEST_OUTPUT_ROM = '0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 start_i,
  input  logic                                 loop_i,
  output logic                                 valid_o,
  input  logic                                 yumi_i,
  output logic [NUM_WORDS*WORD_SIZE-1:0]       data_o,
  output logic                                 ready_o,
  input  logic                                 valid_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]     data_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic [$clog2(NUM_TESTS+1)-1:0]       error_count_o,
  output logic [$clog2(NUM_TESTS)-1:0]         first_fail_o,
  output logic                                 fail_seen_o
);

  localparam int unsigned InW   = NUM_WORDS * WORD_SIZE;
  localparam int unsigned OutW  = OUTPUT_SIZE * WORD_SIZE;
  localparam int unsigned IdxW  = $clog2(NUM_TESTS);
  localparam int unsigned CntW  = $clog2(NUM_TESTS + 1);
  localparam int unsigned InfW  = $clog2(MAX_INFLIGHT + 1);

  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_TESTS - 1);
  localparam logic [CntW-1:0] ErrOne  = CntW'(1);
  localparam logic [CntW-1:0] ErrMax  = CntW'(NUM_TESTS);
  localparam logic [InfW-1:0] InfOne  = InfW'(1);
  localparam logic [InfW-1:0] InfMax  = InfW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   send_idx_q, send_idx_d;
  logic [IdxW-1:0]   recv_idx_q, recv_idx_d;
  logic [InfW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0]   err_cnt_q, err_cnt_d;
  logic [IdxW-1:0]   first_fail_q, first_fail_d;
  logic              fail_seen_q, fail_seen_d;
  logic [InW-1:0]    data_q, data_d;
  logic              loop_q, loop_d;
  logic              busy_q, done_q, pass_q;
  logic              busy_d, done_d, pass_d;

  logic              send_fire, recv_fire, vec_fail;
  logic              start_pass, clear_stats;

  // ROM views
  logic [InW-1:0]  in_rom  [NUM_TESTS];
  logic [OutW-1:0] out_rom [NUM_TESTS];

  for (genvar i = 0; i < NUM_TESTS; i++) begin : g_rom
    assign in_rom[i]  = TEST_INPUT_ROM[i*InW +: InW];
    assign out_rom[i] = TEST_OUTPUT_ROM[i*OutW +: OutW];
  end

  assign valid_o   = (state_q == StRun) && (inflight_q < InfMax);
  assign ready_o   = (inflight_q != '0);
  assign send_fire = valid_o && yumi_i;
  assign recv_fire = valid_i && ready_o;

  // Word-wise compare against the expected vector at recv_idx.
  // Sign-extending by one bit keeps the difference exact.
  always_comb begin
    logic [OutW-1:0]          exp_vec;
    logic signed [WORD_SIZE:0] act_w, exp_w, diff_w;
    logic [WORD_SIZE:0]        abs_w;
    vec_fail = 1'b0;
    exp_vec  = out_rom[recv_idx_q];
    act_w    = '0;
    exp_w    = '0;
    diff_w   = '0;
    abs_w    = '0;
    for (int w = 0; w < OUTPUT_SIZE; w++) begin
      act_w  = {data_i[w*WORD_SIZE + WORD_SIZE - 1], data_i[w*WORD_SIZE +: WORD_SIZE]};
      exp_w  = {exp_vec[w*WORD_SIZE + WORD_SIZE - 1], exp_vec[w*WORD_SIZE +: WORD_SIZE]};
      diff_w = act_w - exp_w;
      abs_w  = diff_w[WORD_SIZE] ? -diff_w : diff_w;
      if (32'(abs_w) > TOLERANCE) vec_fail = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    send_idx_d   = send_idx_q;
    recv_idx_d   = recv_idx_q;
    inflight_d   = inflight_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    data_d       = data_q;
    loop_d       = loop_q;
    start_pass   = 1'b0;
    clear_stats  = 1'b0;

    // Preload the next entry on the consuming edge so sends can run back to back.
    if (send_fire && (send_idx_q != IdxLast)) begin
      send_idx_d = send_idx_q + IdxOne;
      data_d     = in_rom[send_idx_q + IdxOne];
    end

    if (recv_fire) begin
      if (recv_idx_q != IdxLast) recv_idx_d = recv_idx_q + IdxOne;
      if (vec_fail) begin
        if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrOne;
        if (!fail_seen_q) begin
          first_fail_d = recv_idx_q;
          fail_seen_d  = 1'b1;
        end
      end
    end

    case ({send_fire, recv_fire})
      2'b10:   inflight_d = inflight_q + InfOne;
      2'b01:   inflight_d = inflight_q - InfOne;
      default: ;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_pass  = 1'b1;
          clear_stats = 1'b1;
        end
      end
      StRun: begin
        if (send_fire && (send_idx_q == IdxLast)) state_d = StDrain;
      end
      StDrain: begin
        if (inflight_d == '0) begin
          state_d = StDone;
          loop_d  = loop_i;
        end
      end
      StDone: begin
        // A looped pass keeps accumulating statistics across passes.
        if (loop_q) begin
          start_pass = 1'b1;
        end else if (start_i) begin
          start_pass  = 1'b1;
          clear_stats = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_pass) begin
      state_d    = StRun;
      send_idx_d = '0;
      recv_idx_d = '0;
      data_d     = in_rom[0];
      loop_d     = 1'b0;
    end
    if (clear_stats) begin
      err_cnt_d    = '0;
      first_fail_d = '0;
      fail_seen_d  = 1'b0;
    end

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      send_idx_q   <= '0;
      recv_idx_q   <= '0;
      inflight_q   <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      data_q       <= '0;
      loop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      send_idx_q   <= send_idx_d;
      recv_idx_q   <= recv_idx_d;
      inflight_q   <= inflight_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      data_q       <= data_d;
      loop_q       <= loop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign data_o        = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign error_count_o = err_cnt_q;
  assign first_fail_o  = first_fail_q;
  assign fail_seen_o   = fail_seen_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: 4 vectors of one 8-bit word, 4-word responses,
// MAX_INFLIGHT=2, TOLERANCE=1. A behavioural echo DUT answers with 1-cycle latency.
// Response word w = input + w, plus a per-entry/per-word injected error.
module tb_stream_checker;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i, loop_i, yumi_i, valid_i;
  logic        valid_o, ready_o, busy_o, done_o, pass_o, fail_seen_o;
  logic [7:0]  data_o;
  logic [31:0] data_i;
  logic [2:0]  error_count_o;
  logic [1:0]  first_fail_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] in_tab [4] = '{8'h10, 8'h20, 8'hF0, 8'h7F};
  int         inj [4][4];
  logic [7:0] pend [$];
  bit         stall;
  int sent_tot, recv_tot, cyc;
  int first_send_cyc, last_send_cyc, last_recv_cyc;

  stream_checker #(
    .WORD_SIZE      (8),
    .NUM_WORDS      (1),
    .OUTPUT_SIZE    (4),
    .NUM_TESTS      (4),
    .MAX_INFLIGHT   (2),
    .TOLERANCE      (1),
    .TEST_INPUT_ROM (32'h7FF0_2010),
    .TEST_OUTPUT_ROM(128'h8281807F_F3F2F1F0_23222120_13121110)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .loop_i       (loop_i),
    .valid_o      (valid_o),
    .yumi_i       (yumi_i),
    .data_o       (data_o),
    .ready_o      (ready_o),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .error_count_o(error_count_o),
    .first_fail_o (first_fail_o),
    .fail_seen_o  (fail_seen_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] make_out(input logic [7:0] v, input int idx);
    logic [31:0] r;
    int t;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      t = int'(v) + w + inj[idx][w];
      r[w*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic clear_inj();
    for (int i = 0; i < 4; i++) for (int w = 0; w < 4; w++) inj[i][w] = 0;
  endtask

  task automatic drive_model();
    valid_i = (pend.size() > 0) && !stall;
    data_i  = (pend.size() > 0) ? make_out(pend[0], recv_tot % 4) : 32'h0;
  endtask

  // One clock: log the handshakes seen before the edge, then update the echo DUT after it.
  task automatic tick();
    bit s, g;
    s = valid_o && yumi_i;
    g = valid_i && ready_o;
    if (s) begin
      n_checks++;
      if (data_o !== in_tab[sent_tot % 4]) begin
        n_fail++;
        $display("FAIL send_data: got %h expected %h", data_o, in_tab[sent_tot % 4]);
      end
      if (sent_tot % 4 == 0) first_send_cyc = cyc;
      last_send_cyc = cyc;
      pend.push_back(data_o);
      sent_tot++;
    end
    if (g) begin
      pend.delete(0);
      recv_tot++;
      last_recv_cyc = cyc;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    drive_model();
    n_checks++;
    if (ready_o !== (pend.size() > 0)) begin
      n_fail++;
      $display("FAIL ready_track: got %b expected %b", ready_o, pend.size() > 0);
    end
    n_checks++;
    if (pend.size() > 2) begin
      n_fail++;
      $display("FAIL inflight_limit: got %0d expected <= 2", pend.size());
    end
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done();
    int budget;
    budget = 0;
    while (done_o !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_timeout: got done_o=%b expected 1", done_o);
    end
  endtask

  task automatic check_status(input string name, input bit exp_pass, input int exp_err,
                              input int exp_first, input bit exp_seen);
    n_checks++;
    if (pass_o !== exp_pass) begin
      n_fail++; $display("FAIL %s pass_o: got %b expected %b", name, pass_o, exp_pass);
    end
    n_checks++;
    if (error_count_o !== 3'(exp_err)) begin
      n_fail++; $display("FAIL %s error_count: got %0d expected %0d", name, error_count_o, exp_err);
    end
    n_checks++;
    if (first_fail_o !== 2'(exp_first)) begin
      n_fail++; $display("FAIL %s first_fail: got %0d expected %0d", name, first_fail_o, exp_first);
    end
    n_checks++;
    if (fail_seen_o !== exp_seen) begin
      n_fail++; $display("FAIL %s fail_seen: got %b expected %b", name, fail_seen_o, exp_seen);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [15:0] got;
    got = {valid_o, ready_o, busy_o, done_o, pass_o, fail_seen_o, error_count_o,
           first_fail_o, 3'b000};
    n_checks++;
    if (got !== 16'h0) begin
      n_fail++; $display("FAIL %s flags: got %h expected 0000", name, got);
    end
    n_checks++;
    if (data_o !== 8'h00) begin
      n_fail++; $display("FAIL %s data_o: got %h expected 00", name, data_o);
    end
  endtask

  task automatic test_reset();
    check_all_zero("reset");
  endtask

  task automatic test_basic();
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid: got %b expected 0", valid_o);
    end
    start_run();
    n_checks++;
    if ({valid_o, busy_o, data_o} !== {2'b11, 8'h10}) begin
      n_fail++;
      $display("FAIL start_load: got v=%b b=%b d=%h expected v=1 b=1 d=10", valid_o, busy_o, data_o);
    end
    run_to_done();
    check_status("basic", 1'b1, 0, 0, 1'b0);
    n_checks++;
    if (last_send_cyc - first_send_cyc !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: got span %0d expected 3", last_send_cyc - first_send_cyc);
    end
    n_checks++;
    if (last_recv_cyc !== cyc - 1) begin
      n_fail++;
      $display("FAIL done_latency: got recv cyc %0d expected %0d", last_recv_cyc, cyc - 1);
    end
    n_checks++;
    if (sent_tot !== 4 || recv_tot !== 4) begin
      n_fail++; $display("FAIL basic_counts: got %0d/%0d expected 4/4", sent_tot, recv_tot);
    end
  endtask

  task automatic test_tolerance();
    clear_inj();
    inj[2][3] = 1;
    start_run(); run_to_done();
    check_status("tol_plus1", 1'b1, 0, 0, 1'b0);
    inj[2][3] = 2;
    start_run(); run_to_done();
    check_status("tol_plus2", 1'b0, 1, 2, 1'b1);
    inj[2][3] = -2;
    start_run(); run_to_done();
    check_status("tol_minus2", 1'b0, 1, 2, 1'b1);
    clear_inj();
  endtask

  task automatic test_multi_fail();
    // Entry 3 word 0: 0x80 against 0x7F is -128 vs 127, not a difference of 1.
    clear_inj();
    inj[1][0] = -2;
    inj[3][0] = 1;
    start_run(); run_to_done();
    check_status("multi_fail", 1'b0, 2, 1, 1'b1);
    clear_inj();
  endtask

  task automatic test_stall();
    int base;
    base  = sent_tot;
    stall = 1'b1;
    start_run();
    for (int i = 0; i < 10; i++) begin
      yumi_i = i[0];
      tick();
    end
    yumi_i = 1'b1;
    n_checks++;
    if (sent_tot - base !== 2 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_sends: got %0d sends v=%b expected 2 v=0", sent_tot - base, valid_o);
    end
    n_checks++;
    if (data_o !== 8'hF0) begin
      n_fail++; $display("FAIL stall_hold: got %h expected f0", data_o);
    end
    stall = 1'b0;
    drive_model();
    tick();
    tick();
    n_checks++;
    if ({valid_o, ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL same_cycle_inflight: got v=%b r=%b expected 1 1", valid_o, ready_o);
    end
    run_to_done();
    check_status("stall", 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_loop();
    int dones, budget;
    clear_inj();
    inj[2][3] = 2;
    loop_i = 1'b1;
    dones  = 0;
    budget = 0;
    start_run();
    while (dones < 3 && budget < 200) begin
      tick();
      budget++;
      if (done_o === 1'b1) begin
        dones++;
        if (dones == 2) loop_i = 1'b0;
        if (dones < 3) begin
          tick();
          n_checks++;
          if ({done_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL loop_restart: got done=%b busy=%b expected 0 1", done_o, busy_o);
          end
        end
      end
    end
    n_checks++;
    if (dones !== 3) begin
      n_fail++; $display("FAIL loop_timeout: got %0d passes expected 3", dones);
    end
    check_status("loop", 1'b0, 3, 2, 1'b1);
    tick(); tick();
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL loop_hold: got done=%b expected 1", done_o);
    end
    clear_inj();
    start_run();
    n_checks++;
    if ({error_count_o, fail_seen_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL start_clear: got err=%0d seen=%b expected 0 0", error_count_o, fail_seen_o);
    end
    run_to_done();
    check_status("after_loop", 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base, budget;
    clear_inj();
    inj[0][0] = 2;
    base   = sent_tot;
    budget = 0;
    start_run();
    while (sent_tot - base < 4 && budget < 50) begin
      tick();
      budget++;
    end
    stall = 1'b1;
    drive_model();
    tick(); tick();
    n_checks++;
    if ({busy_o, done_o, ready_o, fail_seen_o} !== 4'b1011) begin
      n_fail++;
      $display("FAIL drain_state: got b=%b d=%b r=%b f=%b expected 1 0 1 1",
               busy_o, done_o, ready_o, fail_seen_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    pend.delete();
    stall    = 1'b0;
    sent_tot = 0;
    recv_tot = 0;
    clear_inj();
    drive_model();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_run();
    run_to_done();
    check_status("post_reset", 1'b1, 0, 0, 1'b0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    loop_i    = 1'b0;
    yumi_i    = 1'b1;
    valid_i   = 1'b0;
    data_i    = '0;
    stall     = 1'b0;
    sent_tot  = 0;
    recv_tot  = 0;
    cyc       = 0;
    first_send_cyc = 0;
    last_send_cyc  = 0;
    last_recv_cyc  = 0;
    clear_inj();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    test_reset();
    test_basic();
    test_tolerance();
    test_multi_fail();
    test_stall();
    test_loop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
